branch_ctrl_sequencer: RTL and testbench
========================================

// Module: branch_ctrl_sequencer
// PURPOSE
//  Parametrised hardwired control-step sequencer for the datapath. Drives the T0..T6 micro-steps of
//  instruction fetch and conditional branch (PC <- PC + C when CON FF set). Adds three things:
//  a memory-ready handshake in T1, a handshake that hands non-branch opcodes to an external sequencer,
//  and a memory-wait timeout fault. Sits between IR/CON FF and the DataPath control inputs.
// PARAMETERS
//  OPCODE_W      5         width of IR opcode field and of alu_op
//  BR_OPCODE     5'b10011  IR opcode decoded as conditional branch
//  ALU_BR_OP     5'b10011  alu_op value driven in T5 (PC + C add)
//  MEM_WAIT_MAX  15        max cycles in T1 awaiting mem_ready before fault; 1..255
//  CNT_W         16        width of optional branch statistics counters
// PORTS
//  Clock            in   1         rising-edge clock
//  clr              in   1         synchronous reset, active-low
//  run              in   1         1 = sequence; 0 = hold in IDLE after the current instruction completes
//  ir_opcode        in   OPCODE_W  IR[31:27], valid from T3
//  con_ff           in   1         CON FF output, valid the cycle after T3
//  mem_ready        in   1         memory has data for MDR (1-cycle pulse or level)
//  ext_done         in   1         external sequencer finished non-branch instruction
//  PC_out,MAR_enable,IncPC,PC_enable,Read,MDR_enable,MDR_out,IR_enable  out 1  datapath controls
//  Gra,R_out,con_in,Y_enable,C_out,Z_enable,ZLow_out                     out 1  datapath controls
//  alu_op           out  OPCODE_W  ALU operation select
//  ext_go           out  1         request external sequencer to execute IR
//  fault            out  1         sticky memory-timeout flag
//  step             out  4         current state code, for debug
// BEHAVIOUR
//  - Moore FSM. All outputs registered. All controls are 0 outside the states that name them.
//  - Reset (clr==0 at a posedge): state=IDLE, all outputs 0, alu_op=0, fault=0, wait counter=0.
//    Reset takes effect from any state, including mid-instruction.
//  - Per-state outputs and transitions:
//    IDLE: run ? T0 : IDLE.
//    T0: PC_out, MAR_enable, IncPC, PC_enable. -> T1.
//    T1: Read, MDR_enable. mem_ready -> T2.
//        Otherwise the wait counter increments. When the counter reaches MEM_WAIT_MAX: fault<=1 -> IDLE.
//    T2: MDR_out, IR_enable. Wait counter cleared. -> T3.
//    T3: Gra, R_out, con_in. -> T4 if ir_opcode==BR_OPCODE, else -> EXT.
//    T4: PC_out, Y_enable. -> T5.
//    T5: C_out, Z_enable, alu_op=ALU_BR_OP. -> T6.
//    T6: ZLow_out. PC_enable=con_ff (branch not taken: PC unchanged). -> run ? T0 : IDLE.
//    EXT: ext_go=1 until the cycle ext_done is sampled high. -> run ? T0 : IDLE.
//  - Latency: taken or not-taken branch = 7 cycles if mem_ready arrives in the first T1 cycle.
//    Each extra wait cycle adds 1.
//  - mem_ready and ext_done are ignored outside T1 and EXT respectively.
//  - run deasserted mid-instruction does not abort; it is sampled only at IDLE, T6 and EXT exit.
//  - fault is sticky until reset. While fault=1 the FSM stays in IDLE regardless of run.
//  - Wait counter is 8 bit. No wrap: it saturates at MEM_WAIT_MAX.
// CONFIGURATION
//  BR_STATS_EN defined: adds out ports br_taken_cnt, br_nt_cnt [CNT_W-1:0].
//    Each increments in T6 on con_ff=1 / 0 respectively. Both saturate at all-ones. Both reset to 0.
//  BR_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package cpu_ctrl_pkg: state encoding localparams (IDLE=0, T0..T6=1..7, EXT=8);
//    opcode constants (BR_OPCODE default); ALU op constants.
//  - Sub-module br_sat_counter (width-param saturating counter).
//    Used for the wait counter and, when BR_STATS_EN is defined, the stats counters.
//  - Control outputs decoded from next-state into registers, so controls change in the same edge as step.
// TESTING
//  1 Reset: hold clr=0 for 2 cycles mid-T4 -> next cycle step=0, every control output 0, fault=0.
//  2 Taken branch: run=1, ir_opcode=5'b10011, con_ff=1, mem_ready in first T1 cycle ->
//    steps 1..7 in 7 cycles; PC_enable=1 in T6; alu_op=10011 in T5 only.
//  3 Not-taken branch: same as 2 with con_ff=0 -> PC_enable=0 in T6; ZLow_out=1 in T6; next step=T0.
//  4 Memory wait: mem_ready delayed 3 cycles -> Read/MDR_enable high 4 cycles; T2 entered on 5th;
//    with mem_ready never sent and MEM_WAIT_MAX=15 -> fault=1 after 15 T1 cycles, FSM parks in IDLE.
//  5 Non-branch: ir_opcode=5'b00011 -> EXT after T3, ext_go high until ext_done pulsed at cycle+4,
//    then T0; no T4..T6 controls asserted.
//  6 BR_STATS_EN: 3 taken + 2 not-taken branches -> br_taken_cnt=3, br_nt_cnt=2;
//    CNT_W=2 with 5 taken -> br_taken_cnt saturates at 3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state codes, opcode and ALU constants shared by the branch control sequencer.
package cpu_ctrl_pkg;
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0 = 4'd1;
    localparam logic [3:0] S_T1 = 4'd2;
    localparam logic [3:0] S_T2 = 4'd3;
    localparam logic [3:0] S_T3 = 4'd4;
    localparam logic [3:0] S_T4 = 4'd5;
    localparam logic [3:0] S_T5 = 4'd6;
    localparam logic [3:0] S_T6 = 4'd7;
    localparam logic [3:0] S_EXT = 4'd8;
    localparam logic [4:0] BR_OPCODE_DEF = 5'b10011;
    localparam logic [4:0] ALU_BR_OP_DEF = 5'b10011;
    localparam logic [4:0] ALU_NOP = 5'b00000;
endpackage

// File: rtl/br_sat_counter.sv
// br_sat_counter: up-counter that holds at MAX; clr is a synchronous active-low reset, clear a synchronous zero.
module br_sat_counter #(
    parameter int W = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         Clock,
    input  logic         clr,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge Clock)
        if (!clr || clear) count <= '0;
        else if (inc && count != MAX) count <= count + 1'b1;
endmodule

// File: rtl/branch_ctrl_sequencer.sv
// branch_ctrl_sequencer: T0..T6 fetch / conditional-branch control steps with memory wait timeout and external handoff.
// Optional branch statistics counters enabled by defining BR_STATS_EN.
module branch_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] BR_OPCODE = BR_OPCODE_DEF,
    parameter logic [OPCODE_W-1:0] ALU_BR_OP = ALU_BR_OP_DEF,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W = 16
) (
    input  logic                Clock,
    input  logic                clr,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                con_ff,
    input  logic                mem_ready,
    input  logic                ext_done,
    output logic                PC_out,
    output logic                MAR_enable,
    output logic                IncPC,
    output logic                PC_enable,
    output logic                Read,
    output logic                MDR_enable,
    output logic                MDR_out,
    output logic                IR_enable,
    output logic                Gra,
    output logic                R_out,
    output logic                con_in,
    output logic                Y_enable,
    output logic                C_out,
    output logic                Z_enable,
    output logic                ZLow_out,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                ext_go,
    output logic                fault,
    output logic [3:0]          step
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0]    br_taken_cnt,
    output logic [CNT_W-1:0]    br_nt_cnt
`endif
);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
    logic [3:0] nxt;
    logic [7:0] wait_cnt;
    logic       stall;
    logic       timeout;
    assign stall = step == S_T1 && !mem_ready;
    assign timeout = stall && wait_cnt == WAIT_LAST;
    br_sat_counter #(.W(8), .MAX(WAIT_MAX)) u_wait (
        .Clock(Clock), .clr(clr), .clear(step == S_T2), .inc(stall), .count(wait_cnt)
    );
    always_comb begin
        nxt = S_IDLE;
        case (step)
            S_IDLE: nxt = (run && !fault) ? S_T0 : S_IDLE;
            S_T0:   nxt = S_T1;
            S_T1:   nxt = mem_ready ? S_T2 : timeout ? S_IDLE : S_T1;
            S_T2:   nxt = S_T3;
            S_T3:   nxt = (ir_opcode == BR_OPCODE) ? S_T4 : S_EXT;
            S_T4:   nxt = S_T5;
            S_T5:   nxt = S_T6;
            S_T6:   nxt = run ? S_T0 : S_IDLE;
            S_EXT:  nxt = ext_done ? (run ? S_T0 : S_IDLE) : S_EXT;
            default: nxt = S_IDLE;
        endcase
    end
    // Controls decode the next state so they change on the same edge as step.
    always_ff @(posedge Clock) begin
        if (!clr) begin
            step <= S_IDLE;
            {PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable} <= '0;
            {Gra, R_out, con_in, Y_enable, C_out, Z_enable, ZLow_out, ext_go, fault} <= '0;
            alu_op <= '0;
        end else begin
            step <= nxt;
            PC_out <= nxt == S_T0 || nxt == S_T4;
            MAR_enable <= nxt == S_T0;
            IncPC <= nxt == S_T0;
            PC_enable <= nxt == S_T0 || (nxt == S_T6 && con_ff);
            Read <= nxt == S_T1;
            MDR_enable <= nxt == S_T1;
            MDR_out <= nxt == S_T2;
            IR_enable <= nxt == S_T2;
            Gra <= nxt == S_T3;
            R_out <= nxt == S_T3;
            con_in <= nxt == S_T3;
            Y_enable <= nxt == S_T4;
            C_out <= nxt == S_T5;
            Z_enable <= nxt == S_T5;
            alu_op <= (nxt == S_T5) ? ALU_BR_OP : '0;
            ZLow_out <= nxt == S_T6;
            ext_go <= nxt == S_EXT;
            fault <= fault || timeout;
        end
    end
`ifdef BR_STATS_EN
    br_sat_counter #(.W(CNT_W)) u_taken (
        .Clock(Clock), .clr(clr), .clear(1'b0), .inc(step == S_T6 && con_ff), .count(br_taken_cnt)
    );
    br_sat_counter #(.W(CNT_W)) u_nt (
        .Clock(Clock), .clr(clr), .clear(1'b0), .inc(step == S_T6 && !con_ff), .count(br_nt_cnt)
    );
`endif
endmodule

// File: tb/tb_branch_ctrl_sequencer.sv
// tb_branch_ctrl_sequencer: directed checks of reset, branch, memory wait/timeout and external handoff.
module tb_branch_ctrl_sequencer;
    logic Clock = 1'b0;
    logic clr, run, con_ff, mem_ready, ext_done;
    logic [4:0] ir_opcode;
    logic PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable;
    logic Gra, R_out, con_in, Y_enable, C_out, Z_enable, ZLow_out, ext_go, fault;
    logic [4:0] alu_op;
    logic [3:0] step;
    int checks = 0;
    int errors = 0;
`ifdef BR_STATS_EN
    logic [15:0] br_taken_cnt, br_nt_cnt;
    logic [1:0] s_taken, s_nt;
    logic s_c0, s_c1, s_c2, s_c3, s_c4, s_c5, s_c6, s_c7, s_c8, s_c9, s_c10, s_c11, s_c12, s_c13, s_c14, s_go, s_fault;
    logic [4:0] s_alu;
    logic [3:0] s_step;
`endif
    branch_ctrl_sequencer u_dut (
        .Clock(Clock), .clr(clr), .run(run), .ir_opcode(ir_opcode), .con_ff(con_ff),
        .mem_ready(mem_ready), .ext_done(ext_done), .PC_out(PC_out), .MAR_enable(MAR_enable),
        .IncPC(IncPC), .PC_enable(PC_enable), .Read(Read), .MDR_enable(MDR_enable),
        .MDR_out(MDR_out), .IR_enable(IR_enable), .Gra(Gra), .R_out(R_out), .con_in(con_in),
        .Y_enable(Y_enable), .C_out(C_out), .Z_enable(Z_enable), .ZLow_out(ZLow_out),
        .alu_op(alu_op), .ext_go(ext_go), .fault(fault), .step(step)
`ifdef BR_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_nt_cnt(br_nt_cnt)
`endif
    );
`ifdef BR_STATS_EN
    branch_ctrl_sequencer #(.CNT_W(2)) u_sat (
        .Clock(Clock), .clr(clr), .run(run), .ir_opcode(ir_opcode), .con_ff(con_ff),
        .mem_ready(mem_ready), .ext_done(ext_done), .PC_out(s_c0), .MAR_enable(s_c1),
        .IncPC(s_c2), .PC_enable(s_c3), .Read(s_c4), .MDR_enable(s_c5),
        .MDR_out(s_c6), .IR_enable(s_c7), .Gra(s_c8), .R_out(s_c9), .con_in(s_c10),
        .Y_enable(s_c11), .C_out(s_c12), .Z_enable(s_c13), .ZLow_out(s_c14),
        .alu_op(s_alu), .ext_go(s_go), .fault(s_fault), .step(s_step),
        .br_taken_cnt(s_taken), .br_nt_cnt(s_nt)
    );
`endif
    always #5 Clock = ~Clock;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, step=%0d", step);
        $fatal(1, "watchdog");
    end
    function automatic logic [16:0] ctl();
        return {PC_out, MAR_enable, IncPC, PC_enable, Read, MDR_enable, MDR_out, IR_enable,
                Gra, R_out, con_in, Y_enable, C_out, Z_enable, ZLow_out, ext_go, fault};
    endfunction
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask
    task automatic drain();
        int n = 0;
        run = 1'b0;
        mem_ready = 1'b1;
        ext_done = 1'b1;
        while (step != 4'd0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (step !== 4'd0) begin
            errors++;
            $display("FAIL drain_to_idle: step=%0d required 0", step);
        end
        ext_done = 1'b0;
    endtask
    task automatic test_reset();
        run = 1'b1; ir_opcode = 5'b10011; con_ff = 1'b1; mem_ready = 1'b1; ext_done = 1'b0;
        repeat (5) tick();
        checks++;
        if (step !== 4'd5) begin errors++; $display("FAIL reset_reach_t4: step=%0d required 5", step); end
        clr = 1'b0; run = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        checks++;
        if (step !== 4'd0) begin errors++; $display("FAIL reset_step: step=%0d required 0", step); end
        checks++;
        if (ctl() !== 17'd0) begin errors++; $display("FAIL reset_controls: ctl=%h required 0", ctl()); end
        checks++;
        if (alu_op !== 5'd0) begin errors++; $display("FAIL reset_alu_op: alu_op=%b required 0", alu_op); end
        tick();
        checks++;
        if (step !== 4'd0) begin errors++; $display("FAIL reset_hold_idle: step=%0d required 0", step); end
    endtask
    task automatic test_branch(input logic c);
        run = 1'b1; ir_opcode = 5'b10011; con_ff = c; mem_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (step !== 4'(i)) begin errors++; $display("FAIL br%0d_step: step=%0d required %0d", c, step, i); end
            checks++;
            if (alu_op !== ((i == 6) ? 5'b10011 : 5'b00000))
                begin errors++; $display("FAIL br%0d_alu_op: step=%0d alu_op=%b", c, i, alu_op); end
        end
        checks++;
        if (PC_enable !== c) begin errors++; $display("FAIL br%0d_pc_enable_t6: got %b required %b", c, PC_enable, c); end
        checks++;
        if (ZLow_out !== 1'b1 || Y_enable !== 1'b0)
            begin errors++; $display("FAIL br%0d_t6_ctl: ZLow_out=%b Y_enable=%b required 1 0", c, ZLow_out, Y_enable); end
        tick();
        checks++;
        if (step !== 4'd1 || PC_out !== 1'b1 || IncPC !== 1'b1)
            begin errors++; $display("FAIL br%0d_next_t0: step=%0d PC_out=%b IncPC=%b", c, step, PC_out, IncPC); end
        drain();
    endtask
    task automatic test_mem_wait();
        int reads = 0;
        run = 1'b1; ir_opcode = 5'b10011; con_ff = 1'b1; mem_ready = 1'b0;
        repeat (2) tick();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (step !== 4'd2) begin errors++; $display("FAIL wait_in_t1: cycle %0d step=%0d required 2", k, step); end
            if (Read && MDR_enable) reads++;
            mem_ready = (k == 4);
            tick();
        end
        checks++;
        if (reads != 4) begin errors++; $display("FAIL wait_read_cycles: got %0d required 4", reads); end
        checks++;
        if (step !== 4'd3 || MDR_out !== 1'b1 || Read !== 1'b0)
            begin errors++; $display("FAIL wait_t2: step=%0d MDR_out=%b Read=%b", step, MDR_out, Read); end
        drain();
    endtask
    task automatic test_timeout();
        run = 1'b1; ir_opcode = 5'b10011; mem_ready = 1'b0;
        repeat (2) tick();
        for (int k = 1; k <= 15; k++) begin
            checks++;
            if (step !== 4'd2 || fault !== 1'b0)
                begin errors++; $display("FAIL timeout_t1: cycle %0d step=%0d fault=%b", k, step, fault); end
            if (k < 15) tick();
        end
        tick();
        checks++;
        if (step !== 4'd0 || fault !== 1'b1)
            begin errors++; $display("FAIL timeout_fault: step=%0d fault=%b required 0 1", step, fault); end
        mem_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (step !== 4'd0 || fault !== 1'b1)
            begin errors++; $display("FAIL timeout_park: step=%0d fault=%b required 0 1", step, fault); end
        run = 1'b0; clr = 1'b0;
        tick();
        clr = 1'b1;
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL timeout_clear: fault=%b required 0", fault); end
    endtask
    task automatic test_ext();
        run = 1'b1; ir_opcode = 5'b00011; con_ff = 1'b1; mem_ready = 1'b1; ext_done = 1'b0;
        repeat (5) tick();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (step !== 4'd8 || ext_go !== 1'b1)
                begin errors++; $display("FAIL ext_wait: cycle %0d step=%0d ext_go=%b", k, step, ext_go); end
            checks++;
            if ({Y_enable, C_out, Z_enable, ZLow_out} !== 4'b0 || alu_op !== 5'd0)
                begin errors++; $display("FAIL ext_no_branch_ctl: cycle %0d ctl=%h alu_op=%b", k, ctl(), alu_op); end
            ext_done = (k == 4);
            tick();
        end
        ext_done = 1'b0;
        checks++;
        if (step !== 4'd1 || ext_go !== 1'b0)
            begin errors++; $display("FAIL ext_exit_t0: step=%0d ext_go=%b required 1 0", step, ext_go); end
        drain();
    endtask
`ifdef BR_STATS_EN
    task automatic run_branch(input logic c);
        run = 1'b1; ir_opcode = 5'b10011; con_ff = c; mem_ready = 1'b1;
        repeat (7) tick();
        run = 1'b0;
        tick();
    endtask
    task automatic test_stats();
        clr = 1'b0; run = 1'b0;
        tick();
        clr = 1'b1;
        checks++;
        if (br_taken_cnt !== 16'd0 || br_nt_cnt !== 16'd0)
            begin errors++; $display("FAIL stats_reset: taken=%0d nt=%0d required 0 0", br_taken_cnt, br_nt_cnt); end
        repeat (3) run_branch(1'b1);
        repeat (2) run_branch(1'b0);
        checks++;
        if (br_taken_cnt !== 16'd3 || br_nt_cnt !== 16'd2)
            begin errors++; $display("FAIL stats_count: taken=%0d nt=%0d required 3 2", br_taken_cnt, br_nt_cnt); end
        repeat (2) run_branch(1'b1);
        checks++;
        if (s_taken !== 2'd3 || br_taken_cnt !== 16'd5)
            begin errors++; $display("FAIL stats_saturate: narrow=%0d wide=%0d required 3 5", s_taken, br_taken_cnt); end
    endtask
`endif
    initial begin
        clr = 1'b0; run = 1'b0; ir_opcode = 5'd0; con_ff = 1'b0; mem_ready = 1'b0; ext_done = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        test_reset();
        test_branch(1'b1);
        test_branch(1'b0);
        test_mem_wait();
        test_timeout();
        test_ext();
`ifdef BR_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
